// File: rtl/bias_stream_buffer_pkg.sv
// bias_stream_buffer_pkg: shared state enum, parameter defaults and saturating shift.
package bias_stream_buffer_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    localparam int DEF_X_PE       = 16;
    localparam int DEF_ADDR_LEN   = 9;
    localparam int DEF_DATA_LEN   = 64;
    localparam int DEF_BIAS_IN_W  = 8;
    localparam int DEF_BIAS_OUT_W = 20;
    localparam int DEF_SHIFT_W    = 5;
    localparam int DEF_LEN_W      = 8;

    // Wide intermediate so a 16-bit element shifted by up to 31 never wraps before clamping.
    function automatic logic signed [31:0] sat_shift(input logic signed [31:0] v, input int sh,
                                                     input int out_w, output logic sat);
        logic signed [63:0] x, hi, lo;
        x = 64'(v) <<< sh;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        sat = (x > hi) || (x < lo);
        return (x > hi) ? hi[31:0] : (x < lo) ? lo[31:0] : x[31:0];
    endfunction
endpackage

// File: rtl/bias_bank_ram.sv
// bias_bank_ram: simple dual-port RAM with a registered read; a colliding read returns old data.
module bias_bank_ram #(
    parameter int ADDR_LEN = 9,
    parameter int DATA_LEN = 64
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] wr_addr,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_LEN-1:0] rd_addr,
    output logic [DATA_LEN-1:0] rd_data
);
    logic [DATA_LEN-1:0] mem [2**ADDR_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/bias_stream_buffer.sv
// bias_stream_buffer: banked bias RAM streamed out as shifted, saturated lanes through a 2-entry FIFO.
module bias_stream_buffer
    import bias_stream_buffer_pkg::*;
#(
    parameter int X_PE       = DEF_X_PE,
    parameter int ADDR_LEN   = DEF_ADDR_LEN,
    parameter int DATA_LEN   = DEF_DATA_LEN,
    parameter int BIAS_IN_W  = DEF_BIAS_IN_W,
    parameter int BIAS_OUT_W = DEF_BIAS_OUT_W,
    parameter int SHIFT_W    = DEF_SHIFT_W,
    parameter int LEN_W      = DEF_LEN_W,
    localparam int BANKS     = X_PE * BIAS_IN_W / DATA_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BANKS*DATA_LEN-1:0]  wr_data,
    input  logic [ADDR_LEN-1:0]        wr_addr,
    input  logic [BANKS-1:0]           wr_en,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [ADDR_LEN-1:0]        cfg_addr,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic                       cfg_usebias,
    output logic                       bias_valid,
    input  logic                       bias_ready,
    output logic [X_PE*BIAS_OUT_W-1:0] bias_data,
    output logic                       bias_last,
    output logic                       bias_sat,
    output logic                       idle
);
    localparam int OUT_W = X_PE * BIAS_OUT_W;

    if (X_PE * BIAS_IN_W % DATA_LEN != 0) begin : g_bad_banks
        $error("X_PE*BIAS_IN_W must be a multiple of DATA_LEN");
    end
    if (BIAS_OUT_W < BIAS_IN_W) begin : g_bad_out_w
        $error("BIAS_OUT_W must be >= BIAS_IN_W");
    end

    state_t                    state;
    logic [ADDR_LEN-1:0]       addr;
    logic [LEN_W-1:0]          rem;
    logic [SHIFT_W-1:0]        shift_q;
    logic                      use_q, inf, inf_last, issue, rd_en, pop, sat_any, s;
    logic [2:0]                occ;
    logic [BANKS*DATA_LEN-1:0] rd_all;
    logic [OUT_W-1:0]          lanes;
    logic [OUT_W-1:0]          fd [2];
    logic                      fl [2];
    logic                      fs [2];
    logic                      wp, rp;
    logic [1:0]                cnt;

    for (genvar k = 0; k < BANKS; k++) begin : g_bank
        bias_bank_ram #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) u_ram (
            .clk(clk),
            .wr_en(wr_en[k]),
            .wr_addr(wr_addr),
            .wr_data(wr_data[k*DATA_LEN +: DATA_LEN]),
            .rd_en(rd_en),
            .rd_addr(addr),
            .rd_data(rd_all[k*DATA_LEN +: DATA_LEN])
        );
    end

    // Count this cycle's pop as free space so a steady ready stream never bubbles.
    assign pop   = bias_valid && bias_ready;
    assign occ   = 3'(cnt) + 3'(inf) - 3'(pop);
    assign issue = (state == S_RUN) && (occ < 3'd2);
    assign rd_en = issue && use_q;

    always_comb begin
        lanes   = '0;
        sat_any = 1'b0;
        s       = 1'b0;
        for (int j = 0; j < X_PE; j++) begin
            lanes[j*BIAS_OUT_W +: BIAS_OUT_W] = BIAS_OUT_W'(sat_shift(
                32'(signed'(rd_all[j*BIAS_IN_W +: BIAS_IN_W])), int'(shift_q), BIAS_OUT_W, s));
            sat_any = sat_any | s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            rem      <= '0;
            shift_q  <= '0;
            use_q    <= 1'b0;
            inf      <= 1'b0;
            inf_last <= 1'b0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= '0;
            fd[0]    <= '0;
            fd[1]    <= '0;
            fl[0]    <= 1'b0;
            fl[1]    <= 1'b0;
            fs[0]    <= 1'b0;
            fs[1]    <= 1'b0;
        end else begin
            inf      <= issue;
            inf_last <= issue && (rem == '0);
            case (state)
                S_IDLE: if (cfg_valid) begin
                    addr    <= cfg_addr;
                    rem     <= cfg_len;
                    shift_q <= cfg_shift;
                    use_q   <= cfg_usebias;
                    state   <= S_RUN;
                end
                S_RUN: if (issue) begin
                    addr <= addr + ADDR_LEN'(1);
                    rem  <= rem - LEN_W'(1);
                    if (rem == '0) state <= S_DRAIN;
                end
                default: if (pop && bias_last) state <= S_IDLE;
            endcase
            if (inf) begin
                fd[wp] <= use_q ? lanes : '0;
                fl[wp] <= inf_last;
                fs[wp] <= use_q && sat_any;
                wp     <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(inf) - 2'(pop);
        end
    end

    assign bias_valid = (cnt != '0);
    assign bias_data  = fd[rp];
    assign bias_last  = fl[rp];
    assign bias_sat   = fs[rp];
    assign cfg_ready  = (state == S_IDLE);
    assign idle       = cfg_ready && (cnt == '0);
endmodule

// File: tb/tb_bias_stream_buffer.sv
// tb_bias_stream_buffer: directed bench for the bias stream buffer with hand-computed lane values.
module tb_bias_stream_buffer;
    localparam int X  = 16;
    localparam int OW = 20;
    localparam int DW = X * OW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  wr_data;
    logic [8:0]    wr_addr;
    logic [1:0]    wr_en;
    logic          cfg_valid, cfg_ready, cfg_usebias;
    logic [8:0]    cfg_addr;
    logic [7:0]    cfg_len;
    logic [4:0]    cfg_shift;
    logic          bias_valid, bias_ready, bias_last, bias_sat, idle;
    logic [DW-1:0] bias_data;

    int checks = 0;
    int errors = 0;
    int base [16];
    int satv [16];
    int wv   [4][16];

    always #5 clk = ~clk;

    bias_stream_buffer dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
        .cfg_shift(cfg_shift), .cfg_usebias(cfg_usebias), .bias_valid(bias_valid),
        .bias_ready(bias_ready), .bias_data(bias_data), .bias_last(bias_last),
        .bias_sat(bias_sat), .idle(idle)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int v [16], input int sh);
        logic [DW-1:0] r;
        longint x;
        r = '0;
        for (int j = 0; j < X; j++) begin
            x = longint'(v[j]) <<< sh;
            if (x > 524287) x = 524287;
            else if (x < -524288) x = -524288;
            r[j*OW +: OW] = x[19:0];
        end
        return r;
    endfunction

    task automatic wr(input logic [8:0] a, input int v [16]);
        wr_addr = a;
        for (int j = 0; j < X; j++) wr_data[j*8 +: 8] = 8'(v[j]);
        wr_en = 2'b11;
        tick();
        wr_en = 2'b00;
    endtask

    task automatic start(input logic [8:0] a, input logic [7:0] l, input logic [4:0] s, input logic u);
        cfg_addr = a; cfg_len = l; cfg_shift = s; cfg_usebias = u; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int k, cyc;
        logic stalled;
        logic [DW-1:0] prev;
        wr_data = '0; wr_addr = '0; wr_en = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_shift = '0; cfg_usebias = 1'b0;
        bias_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", DW'(bias_valid), DW'(0));
        chk("rst_ready", DW'(cfg_ready), DW'(1));
        chk("rst_idle", DW'(idle), DW'(1));
        chk("rst_data", bias_data, '0);
        chk("rst_last_sat", DW'({bias_last, bias_sat}), DW'(0));
        rst = 1'b0;
        for (int j = 0; j < X; j++) begin
            base[j] = j - 8;
            satv[j] = (j % 2 == 0) ? 127 : -128;
            for (int i = 0; i < 4; i++) wv[i][j] = 10 * (i + 1) + j;
        end
        for (int a = 3; a <= 6; a++) wr(9'(a), base);
        wr(9'd20, base);
        wr(9'd100, satv);
        wr(9'd510, wv[0]); wr(9'd511, wv[1]); wr(9'd0, wv[2]); wr(9'd1, wv[3]);

        // basic burst: 4 beats, lane j = 4*(j-8)
        start(9'd3, 8'd3, 5'd2, 1'b1);
        chk("b_lat0", DW'(bias_valid), DW'(0));
        chk("b_busy", DW'({cfg_ready, idle}), DW'(0));
        tick();
        chk("b_lat1", DW'(bias_valid), DW'(0));
        tick();
        for (int b = 0; b < 4; b++) begin
            chk("b_valid", DW'(bias_valid), DW'(1));
            chk("b_data", bias_data, mk(base, 2));
            chk("b_last", DW'(bias_last), DW'(b == 3));
            chk("b_sat", DW'(bias_sat), DW'(0));
            tick();
        end
        chk("b_end_valid", DW'(bias_valid), DW'(0));
        chk("b_end_idle", DW'({cfg_ready, idle}), DW'(3));
        chk("b_lane0", DW'(bias_data[19:0]), DW'(20'hFFFE0));

        // saturation: 127<<31 and -128<<31 clamp to the 20-bit extremes
        start(9'd100, 8'd0, 5'd31, 1'b1);
        tick(); tick();
        chk("s_valid", DW'(bias_valid), DW'(1));
        chk("s_data", bias_data, mk(satv, 31));
        chk("s_pos", DW'(bias_data[19:0]), DW'(20'h7FFFF));
        chk("s_neg", DW'(bias_data[39:20]), DW'(20'h80000));
        chk("s_sat_last", DW'({bias_sat, bias_last}), DW'(3));
        tick();
        chk("s_idle", DW'(idle), DW'(1));

        // backpressure with address wrap 510,511,0,1
        start(9'd510, 8'd3, 5'd0, 1'b1);
        k = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (k < 4 && cyc < 40) begin
            bias_ready = (cyc % 2 == 0);
            if (stalled) chk("w_stable", bias_data, prev);
            if (bias_valid) begin
                chk("w_data", bias_data, mk(wv[k], 0));
                chk("w_last", DW'(bias_last), DW'(k == 3));
                prev = bias_data;
                stalled = !bias_ready;
                if (bias_ready) k++;
            end else stalled = 1'b0;
            cyc++;
            tick();
        end
        chk("w_count", DW'(k), DW'(4));
        bias_ready = 1'b1;
        tick();
        chk("w_end_valid", DW'(bias_valid), DW'(0));
        chk("w_end_idle", DW'(idle), DW'(1));

        // zero mode with an ignored mid-burst request
        start(9'd20, 8'd2, 5'd2, 1'b0);
        cfg_valid = 1'b1; cfg_addr = 9'd3; cfg_usebias = 1'b1;
        chk("z_ready0", DW'(cfg_ready), DW'(0));
        tick();
        chk("z_ready1", DW'(cfg_ready), DW'(0));
        chk("z_lat", DW'(bias_valid), DW'(0));
        cfg_valid = 1'b0;
        tick();
        for (int b = 0; b < 3; b++) begin
            chk("z_valid", DW'(bias_valid), DW'(1));
            chk("z_data", bias_data, '0);
            chk("z_last_sat", DW'({bias_last, bias_sat}), DW'(b == 2 ? 2 : 0));
            tick();
        end
        chk("z_end_idle", DW'({bias_valid, idle}), DW'(1));
        tick(); tick();
        chk("z_no_extra", DW'(bias_valid), DW'(0));

        // reset during beat 2, then a clean burst
        start(9'd3, 8'd3, 5'd2, 1'b1);
        tick(); tick();
        chk("r_beat1", bias_data, mk(base, 2));
        tick();
        chk("r_beat2_valid", DW'(bias_valid), DW'(1));
        rst = 1'b1;
        #1;
        chk("r_valid", DW'(bias_valid), DW'(0));
        chk("r_data", bias_data, '0);
        chk("r_last_sat", DW'({bias_last, bias_sat}), DW'(0));
        chk("r_ready_idle", DW'({cfg_ready, idle}), DW'(3));
        tick();
        rst = 1'b0;
        tick();
        chk("r_hold", DW'({bias_valid, idle}), DW'(1));
        start(9'd3, 8'd0, 5'd0, 1'b1);
        tick(); tick();
        chk("r_new_valid", DW'(bias_valid), DW'(1));
        chk("r_new_data", bias_data, mk(base, 0));
        chk("r_new_last", DW'(bias_last), DW'(1));
        tick();
        chk("r_new_idle", DW'(idle), DW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bias_stream_buffer.md
BIAS_STREAM_BUFFER -- requirements
Module: bias_stream_buffer

Interface
REQ-001 Parameters SHALL be:
- X_PE, 16, output lanes per beat.
- ADDR_LEN, 9, bank address width; RAM_DEPTH = 2**ADDR_LEN.
- DATA_LEN, 64, bank word width.
- BIAS_IN_W, 8, stored bias width (8 or 16).
- BIAS_OUT_W, 20, output lane width; must be >= BIAS_IN_W.
- SHIFT_W, 5, shift-amount width.
- LEN_W, 8, burst-length width.
- BANKS, derived as X_PE*BIAS_IN_W/DATA_LEN; a non-integer result is an elaboration error.
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_data  in  BANKS*DATA_LEN  write word, bank k at slice k.
- wr_addr  in  ADDR_LEN  write address shared by all banks.
- wr_en  in  BANKS  per-bank write enable.
- cfg_valid  in  1  burst request.
- cfg_ready  out  1  request accepted when high with cfg_valid.
- cfg_addr  in  ADDR_LEN  first read address.
- cfg_len  in  LEN_W  beats minus one.
- cfg_shift  in  SHIFT_W  left-shift amount.
- cfg_usebias  in  1  0 = emit zeros.
- bias_valid  out  1  beat valid.
- bias_ready  in  1  consumer ready.
- bias_data  out  X_PE*BIAS_OUT_W  lane j at slice j.
- bias_last  out  1  final beat of the burst.
- bias_sat  out  1  at least one lane saturated on this beat.
- idle  out  1  no burst in progress and output empty.

Function
REQ-003 Writes SHALL complete in one cycle per bank with wr_en[k]=1 and SHALL be independent of the read path.
REQ-004 The RAM read latency SHALL be exactly 1 cycle; for a read and write to the same address in the same cycle, the read SHALL return the old data.
REQ-005 The FSM SHALL have three states:
- IDLE -> RUN on cfg_valid&&cfg_ready.
- RUN -> DRAIN after the last read issues.
- DRAIN -> IDLE when the last beat handshakes.
REQ-006 cfg_ready SHALL be 1 only in IDLE; cfg_valid in any other state SHALL be ignored.
REQ-007 On accept, the block SHALL latch cfg_addr, cfg_len, cfg_shift and cfg_usebias; the latched values SHALL hold for the whole burst.
REQ-008 The burst SHALL emit cfg_len+1 beats from consecutive addresses; the address SHALL wrap from RAM_DEPTH-1 to 0.
REQ-009 The output path SHALL be a 2-entry FIFO, and a read SHALL issue only if FIFO occupancy plus in-flight reads is less than 2.
REQ-010 The first bias_valid SHALL assert 2 cycles after the accept edge; with bias_ready held high, throughput SHALL be 1 beat/cycle with no bubbles.
REQ-011 Lane j SHALL be computed as follows:
- Take stored element j as signed BIAS_IN_W.
- Sign-extend it to BIAS_OUT_W+32.
- Shift it arithmetically left by cfg_shift.
- Saturate it to the signed BIAS_OUT_W range.
REQ-012 bias_sat SHALL be the OR of the per-lane saturation flags of the same beat, registered with that beat's data.
REQ-013 When cfg_usebias=0, the block SHALL issue no RAM reads; it SHALL emit cfg_len+1 all-zero beats with bias_sat=0 under the same handshake and latency.
REQ-014 bias_data, bias_last and bias_sat SHALL stay stable while bias_valid=1 and bias_ready=0.
REQ-015 bias_last SHALL be 1 only on beat cfg_len+1.
REQ-016 idle SHALL be 1 exactly when the state is IDLE and the FIFO is empty.
REQ-017 A back-to-back request SHALL be acceptable on the cycle after DRAIN returns to IDLE.

Reset
REQ-018 rst=1 SHALL asynchronously force the following, regardless of the current state, including mid-burst:
- state to IDLE and FIFO to empty;
- bias_valid, bias_last and bias_sat to 0, and bias_data to all zeros;
- cfg_ready and idle to 1.
REQ-019 RAM contents SHALL NOT be cleared by reset; the first burst after deassertion SHALL behave normally.

Structure
REQ-020 The shared package SHALL hold the state enum, the parameter defaults, and the saturating-shift function.
REQ-021 One sub-module, bias_bank_ram, SHALL be instantiated BANKS times; it is a simple dual-port RAM with a 1-cycle registered read.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Basic burst: write bank words with lane j = j-8; cfg_addr=3, cfg_len=3, shift=2, usebias=1, ready=1 -> 4 beats from addresses 3..6, lane j = 4*(j-8), first valid 2 cycles after accept, bias_last on beat 4 only.
- Saturation: element 127, shift=31, BIAS_OUT_W=20 -> lane 524287, bias_sat=1; element -128, shift=31 -> lane -524288.
- Backpressure and wrap: cfg_addr=510, cfg_len=3, bias_ready toggling 1010... -> addresses 510, 511, 0, 1 in order, no beat lost or duplicated, data stable while stalled.
- Zero mode: usebias=0, cfg_len=2 -> 3 all-zero beats, no RAM reads, cfg_valid asserted mid-burst ignored (cfg_ready=0).
- Mid-burst reset: rst pulses during beat 2 -> outputs clear immediately, idle=1, and a new burst afterward returns correct data.
